// File: rtl/des_perm_pipe.sv
// des_perm_pipe: LANES-wide DES IP / FP / bypass permutation behind an elastic valid/ready pipeline.
// Defining DES_PERM_CNT_EN adds a saturating output beat counter (cnt_clr / beat_cnt).
module des_perm_pipe #(
    parameter int LANES       = 1,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [64*LANES-1:0] in_data,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [64*LANES-1:0] out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err
`ifdef DES_PERM_CNT_EN
    ,
    input  logic                cnt_clr,
    output logic [31:0]         beat_cnt
`endif
);
    localparam int DW = 64 * LANES;

    localparam logic [1:0] MODE_IP  = 2'b00;
    localparam logic [1:0] MODE_FP  = 2'b01;
    localparam logic [1:0] MODE_BYP = 2'b10;

    logic [DW-1:0] ip_data;
    logic [DW-1:0] fp_data;
    logic [DW-1:0] perm_data;
    logic          perm_err;

    // Pure wiring: bit 8r+c of each lane maps to base(c)-r under IP, FP is the reverse.
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        for (genvar gi = 0; gi < 64; gi++) begin : g_bit
            localparam int R    = gi / 8;
            localparam int C    = gi % 8;
            localparam int BASE = (C % 2 == 0) ? 39 + 8 * (C / 2) : 7 + 8 * ((C - 1) / 2);
            localparam int J    = BASE - R;
            assign ip_data[64*gl + J]  = in_data[64*gl + gi];
            assign fp_data[64*gl + gi] = in_data[64*gl + J];
        end
    end

    always_comb begin
        perm_data = in_data;
        perm_err  = 1'b0;
        case (in_mode)
            MODE_IP:  perm_data = ip_data;
            MODE_FP:  perm_data = fp_data;
            MODE_BYP: perm_data = in_data;
            default:  perm_err  = 1'b1;
        endcase
    end

    logic [PIPE_STAGES-1:0] v_q, v_d;
    logic [PIPE_STAGES-1:0] ready;
    logic [DW-1:0]          data_q [PIPE_STAGES];
    logic [DW-1:0]          data_d [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
    logic [TAG_W-1:0]       tag_d  [PIPE_STAGES];
    logic                   err_q  [PIPE_STAGES];
    logic                   err_d  [PIPE_STAGES];

    // Flattened form of ready[s] = !v[s] | ready[s+1]: a stage can move if any later stage is empty.
    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_ready
        assign ready[gi] = out_ready | ~(&v_q[PIPE_STAGES-1:gi]);
    end

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        tag_d  = tag_q;
        err_d  = err_q;
        if (ready[0]) begin
            v_d[0]    = in_valid;
            data_d[0] = perm_data;
            tag_d[0]  = in_tag;
            err_d[0]  = perm_err;
        end
        for (int s = 1; s < PIPE_STAGES; s++) begin
            if (ready[s]) begin
                v_d[s]    = v_q[s-1];
                data_d[s] = data_q[s-1];
                tag_d[s]  = tag_q[s-1];
                err_d[s]  = err_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_q[s] <= '0;
                tag_q[s]  <= '0;
                err_q[s]  <= 1'b0;
            end
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            tag_q  <= tag_d;
            err_q  <= err_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v_q[PIPE_STAGES-1];
    assign out_data  = data_q[PIPE_STAGES-1];
    assign out_tag   = tag_q[PIPE_STAGES-1];
    assign out_err   = err_q[PIPE_STAGES-1];

`ifdef DES_PERM_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_cnt = cnt_q;
`endif
endmodule
